mm_exec_unit: RTL
=================

# mm_exec_unit

Parametrised multi-cycle memory-to-memory execution engine for the next-generation SHER core. It accepts one three-operand command carrying SP-relative word offsets, fetches both sources through a single shared req/ack memory port, and evaluates a funct3-selected ALU operation. It then writes the result back to a third SP-relative slot and maintains a compare flag. Unlike the current fixed-width core, it has generic data and address widths, tolerates variable memory latency, and exposes a valid/ready command handshake to the fetch/decode stage.

## Interface
- DATA_WIDTH, 16, operand/result width
- ADDR_WIDTH, 16, memory byte-address width
- OFFSET_WIDTH, 9, width of each offset field (unsigned)
- SCALE_SHIFT, 1, left shift applied to offsets (word scaling)
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready
- cmd_funct  in  3  ALU operation
- cmd_off1 / cmd_off2 / cmd_offd  in  OFFSET_WIDTH each  source1, source2, destination offsets
- sp  in  ADDR_WIDTH  stack pointer base, sampled at acceptance
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  request completed this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack&~mem_we
- done  out  1  one-cycle completion pulse
- result  out  DATA_WIDTH  last computed result, held until next EXEC
- cmp_flag  out  1  last compare outcome

## Operation
- States: IDLE -> RD1 -> RD2 -> EXEC -> WR -> DONE -> IDLE.
- IDLE: cmd_ready=1. On acceptance, latch funct, sp, and all three offsets.
- Address = sp + (zero-extended offset << SCALE_SHIFT), modulo 2^ADDR_WIDTH.
- RD1/RD2: mem_req=1, mem_we=0, address from off1/off2. On mem_ack, capture mem_rdata into A/B and advance; otherwise hold.
- EXEC: single cycle; result register loads the ALU output.
- ALU funct3 encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, all wrapping.
  - 101 sll: A << B[$clog2(DATA_WIDTH)-1:0].
  - 110 slt: signed A<B.
  - 111 seq: A==B.
- Compare ops (110/111): result = zero-extended cmp bit, and cmp_flag is updated. Other ops leave cmp_flag unchanged.
- WR: mem_req=1, mem_we=1, address from offd, mem_wdata=result. Hold until mem_ack.
- DONE: done=1 for exactly one cycle, then IDLE.
- mem_addr, mem_wdata, and mem_we are 0 whenever mem_req=0.
- mem_ack while mem_req=0 is ignored.
- Reset values: cmd_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, result=0, cmp_flag=0.

## Timing
- mem_ack may arrive in the same cycle as mem_req. Request fields stay stable from mem_req rise until the ack cycle inclusive.
- Zero-wait memory: acceptance at edge 0, RD1 in cycle 1, RD2 in cycle 2, EXEC in cycle 3, WR in cycle 4, done in cycle 5, cmd_ready=1 in cycle 6. Each wait cycle adds one.
- A command is never accepted in DONE; back-to-back throughput is 6 cycles.
- Aliased addresses (off1=off2=offd) are legal. Reads complete before the write.
- Reset mid-operation: state goes to IDLE and mem_req falls asynchronously. The in-flight memory transaction is abandoned, and no done is produced.

## Configuration
- MM_EXEC_CMP_GATE_EN defined:
  - Adds port cmd_cond (in, 1), latched at acceptance.
  - If cmd_cond=1 and cmp_flag=0 at EXEC, WR is skipped and the flow goes EXEC -> DONE, with no memory write. done still pulses, 1 cycle sooner.
  - cmp_flag is then cleared in DONE.
- Undefined: port absent; every command writes back.

## Structure
- Package mm_exec_pkg holds the state enum, funct3 localparams, and the address-calculation function.
- Sub-module mm_exec_alu: purely combinational, parametrised by DATA_WIDTH. Outputs result and cmp.

## Test plan
- Add, zero-wait memory: DATA_WIDTH=16, SCALE_SHIFT=1, sp=0x0100, off1=2, off2=3, offd=4, mem[0x104]=7, mem[0x106]=5, funct=000 -> write 0x000C to 0x108, done in cycle 5.
- Sub wrap and slt: A=3, B=5, funct=001 -> 0xFFFE. A=0xFFFF, B=0x0001, funct=110 -> result 1, cmp_flag=1.
- Wait states: mem_ack delayed 3 cycles in RD2 -> mem_addr held at 0x106 throughout, done in cycle 8.
- Address wrap: sp=0xFFFE, off1=2 -> RD1 mem_addr=0x0002.
- Reset in RD2 -> mem_req=0 in the same cycle, no done, cmd_ready=1 after release. A new command then completes normally.
- MM_EXEC_CMP_GATE_EN: cmp_flag=0 and cmd_cond=1 -> no cycle with mem_we=1, done in cycle 4.

Source files
------------

// File: rtl/mm_exec_pkg.sv
// Shared types for the memory-to-memory execution engine: FSM states, ALU
// function codes and the SP-relative slot address calculation.
package mm_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_EXEC,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_SLL = 3'b101;
  localparam logic [2:0] F_SLT = 3'b110;
  localparam logic [2:0] F_SEQ = 3'b111;

  // Computed at 64 bits; callers keep the low ADDR_WIDTH bits, which gives
  // the modulo-2^ADDR_WIDTH wrap.
  function automatic logic [63:0] calc_addr(input logic [63:0] base,
                                            input logic [63:0] off,
                                            input int          shift);
    return base + (off << shift);
  endfunction

endpackage

// File: rtl/mm_exec_if.sv
// Command and memory-port bundle for mm_exec_unit. Defining
// MM_EXEC_CMP_GATE_EN adds the cmd_cond conditional-writeback bit.
interface mm_exec_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9
);
  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // memory request fields stay stable from mem_req rise through the mem_ack cycle.
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_funct;
  logic [OFFSET_WIDTH-1:0] cmd_off1;
  logic [OFFSET_WIDTH-1:0] cmd_off2;
  logic [OFFSET_WIDTH-1:0] cmd_offd;
  logic [ADDR_WIDTH-1:0]   sp;
`ifdef MM_EXEC_CMP_GATE_EN
  logic                    cmd_cond;
`endif
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  cmd_valid, cmd_funct, cmd_off1, cmd_off2, cmd_offd, sp,
`ifdef MM_EXEC_CMP_GATE_EN
    input  cmd_cond,
`endif
    output cmd_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cmd_valid, cmd_funct, cmd_off1, cmd_off2, cmd_offd, sp,
`ifdef MM_EXEC_CMP_GATE_EN
    output cmd_cond,
`endif
    input  cmd_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mm_exec_alu.sv
// Combinational ALU for mm_exec_unit; compare ops return the flag
// zero-extended on y as well as on cmp.
module mm_exec_alu
  import mm_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            funct,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  cmp
);

  localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  always_comb begin
    y   = '0;
    cmp = 1'b0;
    case (funct)
      F_ADD: y = a + b;
      F_SUB: y = a - b;
      F_AND: y = a & b;
      F_OR:  y = a | b;
      F_XOR: y = a ^ b;
      F_SLL: y = a << b[SHW-1:0];
      F_SLT: begin
        cmp = $signed(a) < $signed(b);
        y   = {{(DATA_WIDTH-1){1'b0}}, cmp};
      end
      F_SEQ: begin
        cmp = (a == b);
        y   = {{(DATA_WIDTH-1){1'b0}}, cmp};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mm_exec_unit.sv
// Multi-cycle memory-to-memory engine: read two SP-relative words, apply the
// ALU, write the result back. MM_EXEC_CMP_GATE_EN enables cmp-gated writeback.
module mm_exec_unit
  import mm_exec_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int SCALE_SHIFT  = 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  mm_exec_if.master             bus,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cmp_flag,
  output state_t                state_dbg
);

  state_t                  state, state_nxt;
  logic [2:0]              funct_q;
  logic [ADDR_WIDTH-1:0]   sp_q;
  logic [OFFSET_WIDTH-1:0] off1_q, off2_q, offd_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [DATA_WIDTH-1:0]   alu_y;
  logic                    alu_cmp;
  logic                    gate_skip;
  logic                    cmd_ready;
  logic                    mem_req, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [ADDR_WIDTH-1:0]   base,
                                                      input logic [OFFSET_WIDTH-1:0] off);
    logic [63:0] full;
    full = calc_addr(64'(base), 64'(off), SCALE_SHIFT);
    return full[ADDR_WIDTH-1:0];
  endfunction

`ifdef MM_EXEC_CMP_GATE_EN
  logic cond_q, skip_q;
  // Gate uses the flag as it stood entering EXEC, before this command's update.
  assign gate_skip = cond_q & ~cmp_flag;
`else
  assign gate_skip = 1'b0;
`endif

  mm_exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .funct(funct_q), .a(a_q), .b(b_q), .y(alu_y), .cmp(alu_cmp)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = ST_RD1;
      end
      ST_RD1: begin
        mem_req  = 1'b1;
        mem_addr = slot_addr(sp_q, off1_q);
        if (bus.mem_ack) state_nxt = ST_RD2;
      end
      ST_RD2: begin
        mem_req  = 1'b1;
        mem_addr = slot_addr(sp_q, off2_q);
        if (bus.mem_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = gate_skip ? ST_DONE : ST_WR;
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = slot_addr(sp_q, offd_q);
        mem_wdata = result;
        if (bus.mem_ack) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      funct_q  <= '0;
      sp_q     <= '0;
      off1_q   <= '0;
      off2_q   <= '0;
      offd_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      cmp_flag <= 1'b0;
`ifdef MM_EXEC_CMP_GATE_EN
      cond_q   <= 1'b0;
      skip_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (bus.cmd_valid) begin
          funct_q <= bus.cmd_funct;
          sp_q    <= bus.sp;
          off1_q  <= bus.cmd_off1;
          off2_q  <= bus.cmd_off2;
          offd_q  <= bus.cmd_offd;
`ifdef MM_EXEC_CMP_GATE_EN
          cond_q  <= bus.cmd_cond;
`endif
        end
        ST_RD1: if (bus.mem_ack) a_q <= bus.mem_rdata;
        ST_RD2: if (bus.mem_ack) b_q <= bus.mem_rdata;
        ST_EXEC: begin
          result <= alu_y;
          if (funct_q == F_SLT || funct_q == F_SEQ) cmp_flag <= alu_cmp;
`ifdef MM_EXEC_CMP_GATE_EN
          skip_q <= gate_skip;
`endif
        end
        ST_DONE: begin
`ifdef MM_EXEC_CMP_GATE_EN
          if (skip_q) cmp_flag <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign state_dbg     = state;

endmodule
